circuito: RTL and testbench

CIRCUITO -- requirements
Module: circuito

---
 rtl/circuito_pkg.sv | 31 +++
 rtl/circuito_rx_serial_8n1.sv | 89 ++++++++
 rtl/circuito.sv | 127 ++++++++++++
 tb/tb_circuito.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/circuito_pkg.sv
// Shared constants, state encodings and ASCII helpers for the serial-to-PWM servo controller.
package circuito_pkg;

    localparam int unsigned CLKS_PER_BIT = 434;
    localparam int unsigned PWM_PERIOD   = 1_000_000;
    localparam int unsigned WIDTH_MIN    = 50_000;
    localparam int unsigned WIDTH_MID    = 75_000;
    localparam int unsigned WIDTH_MAX    = 100_000;
    localparam int unsigned VAL_W        = 7;

    localparam logic [7:0] ASCII_CMD = 8'h30;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;

    typedef enum logic [2:0] {
        WAIT_CMD, MIN_T, MIN_U, MAX_T, MAX_U, CUR_T, CUR_U
    } parse_state_e;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    function automatic logic [3:0] digit_val(input logic [7:0] b);
        return 4'(b - ASCII_0);
    endfunction

endpackage

// File: rtl/circuito_rx_serial_8n1.sv
// UART 8N1 receiver: mid-bit sampling, glitch rejection on the start bit,
// one-clock valid pulse for good bytes and an error pulse for a bad stop bit.
module rx_serial_8n1 #(
    parameter int unsigned CLKS_PER_BIT = circuito_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);
    import circuito_pkg::*;

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    rx_state_e        state_q;
    logic [1:0]       sync_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             rx_s;

    assign rx_s = sync_q[1];

    // prev_q resets low so a line that is low at reset release is not taken as a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            sync_q      <= 2'b00;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rx_i};
            prev_q      <= rx_s;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !rx_s) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                        else               bit_q   <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_s) begin
                            byte_o  <= shift_q;
                            valid_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/circuito.sv
// Servo controller: ASCII frames "0 MM mm CC" over UART set MIN/MAX/CUR, which pick
// a 1.0/1.5/2.0 ms pulse width; the width changes only at a PWM period boundary.
module circuito #(
    parameter int unsigned CLKS_PER_BIT = circuito_pkg::CLKS_PER_BIT,
    parameter int unsigned PWM_PERIOD   = circuito_pkg::PWM_PERIOD,
    parameter int unsigned WIDTH_MIN    = circuito_pkg::WIDTH_MIN,
    parameter int unsigned WIDTH_MID    = circuito_pkg::WIDTH_MID,
    parameter int unsigned WIDTH_MAX    = circuito_pkg::WIDTH_MAX
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada_serial,
    output logic pwm
);
    import circuito_pkg::*;

    localparam int unsigned CNT_SPAN = (PWM_PERIOD > WIDTH_MAX) ? PWM_PERIOD : WIDTH_MAX + 1;
    localparam int unsigned CNT_W    = $clog2(CNT_SPAN);

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_err;

    parse_state_e     state_q;
    logic [3:0]       mt_q, mu_q, xt_q, xu_q, ct_q;
    logic [VAL_W-1:0] min_q, max_q, cur_q;
    logic             commit_q;
    logic [VAL_W-1:0] new_min, new_max, new_cur;
    logic             rx_digit;

    logic             configured_q;
    logic [CNT_W-1:0] cnt_q, width_q, width_pend_q, width_sel;

    rx_serial_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clock),
        .rst         (reset),
        .rx_i        (entrada_serial),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (rx_err)
    );

    always_comb begin
        rx_digit = is_digit(rx_byte);
        new_min  = 7'(mt_q) * 7'd10 + 7'(mu_q);
        new_max  = 7'(xt_q) * 7'd10 + 7'(xu_q);
        new_cur  = 7'(ct_q) * 7'd10 + 7'(digit_val(rx_byte));
    end

    // Frame parser: values are latched on the last digit, the width is derived one clock later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_CMD;
            mt_q     <= '0;
            mu_q     <= '0;
            xt_q     <= '0;
            xu_q     <= '0;
            ct_q     <= '0;
            min_q    <= '0;
            max_q    <= '0;
            cur_q    <= '0;
            commit_q <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            if (rx_err) begin
                state_q <= WAIT_CMD;
            end else if (rx_valid) begin
                if (state_q == WAIT_CMD) begin
                    if (rx_byte == ASCII_CMD) state_q <= MIN_T;
                end else if (!rx_digit) begin
                    state_q <= WAIT_CMD;
                end else begin
                    case (state_q)
                        MIN_T:   begin mt_q <= digit_val(rx_byte); state_q <= MIN_U; end
                        MIN_U:   begin mu_q <= digit_val(rx_byte); state_q <= MAX_T; end
                        MAX_T:   begin xt_q <= digit_val(rx_byte); state_q <= MAX_U; end
                        MAX_U:   begin xu_q <= digit_val(rx_byte); state_q <= CUR_T; end
                        CUR_T:   begin ct_q <= digit_val(rx_byte); state_q <= CUR_U; end
                        default: begin
                            state_q <= WAIT_CMD;
                            if (new_min <= new_max) begin
                                min_q    <= new_min;
                                max_q    <= new_max;
                                cur_q    <= new_cur;
                                commit_q <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        width_sel = CNT_W'(WIDTH_MID);
        if (cur_q < min_q)      width_sel = CNT_W'(WIDTH_MIN);
        else if (cur_q > max_q) width_sel = CNT_W'(WIDTH_MAX);
    end

    // PWM: the running width is swapped only at wrap so every pulse is whole
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            configured_q <= 1'b0;
            cnt_q        <= '0;
            width_q      <= '0;
            width_pend_q <= '0;
            pwm          <= 1'b0;
        end else begin
            if (commit_q) width_pend_q <= width_sel;
            if (!configured_q) begin
                if (commit_q) begin
                    configured_q <= 1'b1;
                    width_q      <= width_sel;
                end
            end else begin
                pwm <= (cnt_q < width_q);
                if (cnt_q == CNT_W'(PWM_PERIOD - 1)) begin
                    cnt_q   <= '0;
                    width_q <= commit_q ? width_sel : width_pend_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_circuito.sv
// Scoreboard bench for circuito: UART frames are driven, a frame-level model predicts the
// pulse width, and an independent monitor measures pwm pulses and periods.
module tb_circuito;

    localparam int unsigned CPB  = 16;
    localparam int unsigned PER  = 400;
    localparam int unsigned WMIN = 50;
    localparam int unsigned WMID = 75;
    localparam int unsigned WMAX = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser = 1'b1;
    logic pwm;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    string name_q[$];
    int hi_cycles = 0;

    int m_pos = 0;
    int m_d[6];
    bit m_cfg = 1'b0;
    int m_width = 0;

    logic mon_prev = 1'b0;
    bit   mon_have_rise = 1'b0;
    int   mon_hi = 0;
    int   mon_since = 0;

    circuito #(
        .CLKS_PER_BIT(CPB), .PWM_PERIOD(PER),
        .WIDTH_MIN(WMIN), .WIDTH_MID(WMID), .WIDTH_MAX(WMAX)
    ) dut (
        .clock          (clk),
        .reset          (rst),
        .entrada_serial (ser),
        .pwm            (pwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_pos = 0;
        m_cfg = 1'b0;
        m_width = 0;
    endfunction

    // Frame rules: command '0', six digits, MIN<=MAX commits, CUR position picks the width
    function automatic void model_byte(input int b);
        if (m_pos == 0) begin
            if (b == 'h30) m_pos = 1;
        end else if (b < 'h30 || b > 'h39) begin
            m_pos = 0;
        end else begin
            m_d[m_pos-1] = b - 'h30;
            m_pos++;
            if (m_pos == 7) begin
                int mn, mx, cu;
                mn = m_d[0] * 10 + m_d[1];
                mx = m_d[2] * 10 + m_d[3];
                cu = m_d[4] * 10 + m_d[5];
                if (mn <= mx) begin
                    m_cfg = 1'b1;
                    m_width = (cu < mn) ? WMIN : (cu > mx) ? WMAX : WMID;
                end
                m_pos = 0;
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk) ser = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser = b[i];
            repeat (CPB) @(negedge clk);
        end
        ser = stop_ok;
        repeat (CPB) @(negedge clk);
        ser = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        if (stop_ok) model_byte(int'(b));
        else         m_pos = 0;
    endtask

    task automatic send_frame(input int mn, input int mx, input int cu);
        send_byte(8'h30, 1'b1);
        send_byte(8'(8'h30 + mn / 10), 1'b1);
        send_byte(8'(8'h30 + mn % 10), 1'b1);
        send_byte(8'(8'h30 + mx / 10), 1'b1);
        send_byte(8'(8'h30 + mx % 10), 1'b1);
        send_byte(8'(8'h30 + cu / 10), 1'b1);
        send_byte(8'(8'h30 + cu % 10), 1'b1);
    endtask

    task automatic expect_width(input string name);
        int t;
        repeat (2 * PER) @(negedge clk);
        if (!m_cfg) begin
            int base;
            base = hi_cycles;
            repeat (PER) @(negedge clk);
            check({name, "_low"}, hi_cycles - base, 0);
        end else begin
            exp_q.push_back(m_width);
            name_q.push_back(name);
            t = 0;
            while (exp_q.size() != 0 && t < 3 * PER) begin
                @(negedge clk);
                t++;
            end
            check({name, "_pulse_seen"}, exp_q.size(), 0);
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic expect_low(input string name);
        int base;
        base = hi_cycles;
        repeat (2 * PER) @(negedge clk);
        check(name, hi_cycles - base, 0);
    endtask

    // Monitor: measures each pulse and the rise-to-rise spacing
    always @(negedge clk) begin
        if (rst) begin
            mon_prev      = 1'b0;
            mon_have_rise = 1'b0;
            mon_hi        = 0;
            mon_since     = 0;
        end else begin
            mon_since++;
            if (pwm) begin
                hi_cycles++;
                mon_hi++;
            end
            if (pwm && !mon_prev) begin
                if (mon_have_rise) check("pwm_period", mon_since, PER);
                mon_have_rise = 1'b1;
                mon_since     = 0;
            end
            if (!pwm && mon_prev) begin
                if (exp_q.size() > 0) check({name_q.pop_front(), "_width"}, mon_hi, exp_q.pop_front());
                mon_hi = 0;
            end
            mon_prev = pwm;
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1;
        ser = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // MIN > MAX while never configured: nothing may start
        send_frame(20, 10, 15);
        expect_low("unconfigured_reject_low");

        send_frame(10, 20, 15);
        expect_width("mid_10_20_15");
        send_frame(10, 20, 5);
        expect_width("low_10_20_05");
        send_frame(10, 20, 25);
        expect_width("high_10_20_25");
        send_frame(20, 10, 15);
        expect_width("reject_keeps_prev");

        // non-digit in MIN tens aborts, next frame commits
        send_byte(8'h30, 1'b1);
        send_byte(8'h41, 1'b1);
        send_frame(10, 20, 15);
        expect_width("after_nondigit_abort");

        // bad stop bit mid-frame aborts the partial frame
        send_byte(8'h30, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h30, 1'b0);
        send_frame(5, 9, 3);
        expect_width("after_badstop_abort");

        // bad-stop command byte and a short low glitch while idle
        send_byte(8'h30, 1'b0);
        @(negedge clk) ser = 1'b0;
        repeat (3) @(negedge clk);
        ser = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_frame(0, 99, 99);
        expect_width("after_glitch_cur_eq_max");

        send_frame(30, 40, 29);
        expect_width("cur_below_min");
        send_frame(30, 40, 30);
        expect_width("cur_eq_min");
        send_frame(30, 40, 41);
        expect_width("cur_above_max");
        send_frame(30, 40, 40);
        expect_width("cur_eq_max");

        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) send_byte(8'(8'h31 + $urandom_range(0, 8)), 1'b1);
            send_frame(int'($urandom_range(0, 99)), int'($urandom_range(0, 99)), int'($urandom_range(0, 99)));
            expect_width("random_frame");
        end

        // reset mid-frame and mid-pulse
        send_byte(8'h30, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(8'h30, 1'b1);
        t = 0;
        while (pwm !== 1'b1 && t < 2 * PER) begin
            @(negedge clk);
            t++;
        end
        check("pulse_before_reset", int'(pwm), 1);
        fork
            send_byte(8'h32, 1'b1);
            begin
                repeat (10) @(negedge clk);
                rst = 1'b1;
                #1;
                check("reset_async_pwm", int'(pwm), 0);
            end
        join
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        name_q.delete();
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        send_byte(8'h35, 1'b1);
        expect_low("after_reset_low");
        send_frame(10, 20, 25);
        expect_width("after_reset_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
